// File: rtl/tdl_link_sup_pkg.sv
// Shared types for the TDL link supervisor: state encodings and counter widths.
package tdl_link_sup_pkg;

    typedef enum logic [2:0] {
        GT_RESET  = 3'd0,
        WAIT_DONE = 3'd1,
        WAIT_LINK = 3'd2,
        RX_RESET  = 3'd3,
        LINKED    = 3'd4,
        FAULT     = 3'd5
    } sup_state_t;

    localparam int unsigned CNT_W = 32;

endpackage

// File: rtl/tdl_link_sup_btn.sv
// User restart button: 2-FF synchronizer plus one-cycle accept pulse.
// TDL_LINK_SUP_DEBOUNCE_EN selects a debounced accept instead of a plain rising-edge accept.
module tdl_link_sup_btn
    import tdl_link_sup_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk_freerun,
    input  logic reset,
    input  logic btn_reset,
    output logic accept
);

    logic sync_1;
    logic sync_2;

    always_ff @(posedge clk_freerun) begin
        if (reset) begin
            sync_1 <= 1'b0;
            sync_2 <= 1'b0;
        end else begin
            sync_1 <= btn_reset;
            sync_2 <= sync_1;
        end
    end

`ifdef TDL_LINK_SUP_DEBOUNCE_EN
    logic [CNT_W-1:0] high_cnt;
    logic             taken;

    // taken blocks further accepts until the button is seen low again
    always_ff @(posedge clk_freerun) begin
        if (reset) begin
            high_cnt <= '0;
            taken    <= 1'b0;
            accept   <= 1'b0;
        end else begin
            accept <= 1'b0;
            if (!sync_2) begin
                high_cnt <= '0;
                taken    <= 1'b0;
            end else if (!taken) begin
                if (high_cnt == DEBOUNCE_CYCLES - 1) begin
                    accept <= 1'b1;
                    taken  <= 1'b1;
                end else begin
                    high_cnt <= high_cnt + 1'b1;
                end
            end
        end
    end
`else
    logic sync_2_d;

    always_ff @(posedge clk_freerun) begin
        if (reset) begin
            sync_2_d <= 1'b0;
            accept   <= 1'b0;
        end else begin
            sync_2_d <= sync_2;
            accept   <= sync_2 & ~sync_2_d;
        end
    end
`endif

endmodule

// File: rtl/tdl_link_supervisor.sv
// Transceiver bring-up / link supervisor: GT reset, done wait, link qualification, retries, fault.
// Button restart filtering is selected by TDL_LINK_SUP_DEBOUNCE_EN (see tdl_link_sup_btn).
//
// state     | meaning
// GT_RESET  | full transceiver reset pulse, RESET_CYCLES long
// WAIT_DONE | waiting for TX and RX reset-done
// WAIT_LINK | qualifying link_status_in for STABLE_CYCLES
// RX_RESET  | RX datapath reset pulse, RESET_CYCLES long
// LINKED    | link qualified, watching for loss
// FAULT     | retries exhausted, waiting for a button restart
module tdl_link_supervisor
    import tdl_link_sup_pkg::*;
#(
    parameter int unsigned RESET_CYCLES    = 1024,
    parameter int unsigned TIMEOUT_CYCLES  = 10_000_000,
    parameter int unsigned STABLE_CYCLES   = 65536,
    parameter int unsigned MAX_RETRIES     = 8,
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic        clk_freerun,
    input  logic        reset,
    input  logic        btn_reset,
    input  logic        tx_done_in,
    input  logic        rx_done_in,
    input  logic        link_status_in,
    output logic        gt_reset_out,
    output logic        rx_datapath_reset_out,
    output logic        link_up,
    output logic        fault,
    output logic [7:0]  retry_count,
    output logic [15:0] loss_count,
    output logic [2:0]  state_out
);

    sup_state_t       state;
    sup_state_t       state_nxt;
    sup_state_t       retry_tgt;
    logic             retry_req;
    logic             enter;
    logic [7:0]       rc_nxt;
    logic [15:0]      lc_nxt;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] stable_cnt;
    logic             btn_accept;
    logic             dones_ok;

    tdl_link_sup_btn #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn (
        .clk_freerun(clk_freerun),
        .reset      (reset),
        .btn_reset  (btn_reset),
        .accept     (btn_accept)
    );

    assign dones_ok = tx_done_in & rx_done_in;

    always_comb begin
        state_nxt = state;
        retry_req = 1'b0;
        retry_tgt = GT_RESET;
        rc_nxt    = retry_count;
        lc_nxt    = loss_count;
        case (state)
            GT_RESET:  if (timer == RESET_CYCLES - 1) state_nxt = WAIT_DONE;
            WAIT_DONE: begin
                if (dones_ok) begin
                    state_nxt = WAIT_LINK;
                end else if (timer == TIMEOUT_CYCLES - 1) begin
                    retry_req = 1'b1;
                    retry_tgt = GT_RESET;
                end
            end
            // losing reset-done outranks both qualification and timeout
            WAIT_LINK: begin
                if (!dones_ok) begin
                    retry_req = 1'b1;
                    retry_tgt = GT_RESET;
                end else if (link_status_in && stable_cnt == STABLE_CYCLES - 1) begin
                    state_nxt = LINKED;
                    rc_nxt    = 8'd0;
                end else if (timer == TIMEOUT_CYCLES - 1) begin
                    retry_req = 1'b1;
                    retry_tgt = RX_RESET;
                end
            end
            RX_RESET:  if (timer == RESET_CYCLES - 1) state_nxt = WAIT_LINK;
            LINKED: begin
                if (!dones_ok) begin
                    retry_req = 1'b1;
                    retry_tgt = GT_RESET;
                end else if (!link_status_in) begin
                    retry_req = 1'b1;
                    retry_tgt = RX_RESET;
                    lc_nxt    = (loss_count == 16'hFFFF) ? loss_count : loss_count + 16'd1;
                end
            end
            default:   state_nxt = FAULT;
        endcase
        if (retry_req) begin
            if ({24'd0, retry_count} < MAX_RETRIES) begin
                rc_nxt    = retry_count + 8'd1;
                state_nxt = retry_tgt;
            end else begin
                state_nxt = FAULT;
            end
        end
        if (btn_accept) begin
            state_nxt = GT_RESET;
            rc_nxt    = 8'd0;
            lc_nxt    = loss_count;
        end
        enter = btn_accept || (state_nxt != state);
    end

    // outputs are registered from the next state so they line up with the state register
    always_ff @(posedge clk_freerun) begin
        if (reset) begin
            state                 <= GT_RESET;
            timer                 <= '0;
            stable_cnt            <= '0;
            gt_reset_out          <= 1'b1;
            rx_datapath_reset_out <= 1'b0;
            link_up               <= 1'b0;
            fault                 <= 1'b0;
            retry_count           <= 8'd0;
            loss_count            <= 16'd0;
            state_out             <= 3'd0;
        end else begin
            state                 <= state_nxt;
            timer                 <= enter ? '0 : timer + 1'b1;
            stable_cnt            <= (!enter && state == WAIT_LINK && link_status_in)
                                     ? stable_cnt + 1'b1 : '0;
            gt_reset_out          <= (state_nxt == GT_RESET) || (state_nxt == FAULT);
            rx_datapath_reset_out <= (state_nxt == RX_RESET);
            link_up               <= (state_nxt == LINKED);
            fault                 <= (state_nxt == FAULT);
            retry_count           <= rc_nxt;
            loss_count            <= lc_nxt;
            state_out             <= state_nxt;
        end
    end

endmodule

// File: tb/tb_tdl_link_supervisor.sv
// Scoreboard bench for tdl_link_supervisor: every state change is checked against a queued expectation.
`timescale 1ns/1ps
module tb_tdl_link_supervisor;
    import tdl_link_sup_pkg::*;

    localparam int RC = 4, TO = 100, SC = 8, MR = 3, DB = 16;

    logic        clk_freerun = 1'b0;
    logic        reset = 1'b1;
    logic        btn_reset = 1'b0;
    logic        tx_done_in = 1'b0;
    logic        rx_done_in = 1'b0;
    logic        link_status_in = 1'b0;
    logic        gt_reset_out, rx_datapath_reset_out, link_up, fault;
    logic [7:0]  retry_count;
    logic [15:0] loss_count;
    logic [2:0]  state_out;

    typedef struct {
        logic [2:0]  st;
        logic        gt, rx, lu, flt;
        logic [7:0]  rc;
        logic [15:0] lc;
        int          dwell;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    always #5 clk_freerun = ~clk_freerun;

    tdl_link_supervisor #(
        .RESET_CYCLES(RC), .TIMEOUT_CYCLES(TO), .STABLE_CYCLES(SC),
        .MAX_RETRIES(MR), .DEBOUNCE_CYCLES(DB)
    ) dut (
        .clk_freerun          (clk_freerun),
        .reset                (reset),
        .btn_reset            (btn_reset),
        .tx_done_in           (tx_done_in),
        .rx_done_in           (rx_done_in),
        .link_status_in       (link_status_in),
        .gt_reset_out         (gt_reset_out),
        .rx_datapath_reset_out(rx_datapath_reset_out),
        .link_up              (link_up),
        .fault                (fault),
        .retry_count          (retry_count),
        .loss_count           (loss_count),
        .state_out            (state_out)
    );

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endfunction

    // expected flags follow from the state: GT reset in GT_RESET/FAULT, RX reset in RX_RESET only
    task automatic push(input logic [2:0] st, input int rc, input int lc, input int dwell);
        exp_t e;
        e.st    = st;
        e.gt    = (st == 3'd0) || (st == 3'd5);
        e.rx    = (st == 3'd3);
        e.lu    = (st == 3'd4);
        e.flt   = (st == 3'd5);
        e.rc    = rc[7:0];
        e.lc    = lc[15:0];
        e.dwell = dwell;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_freerun);
        #1;
    endtask

    task automatic wait_state(input logic [2:0] st, input int budget);
        int n = 0;
        while (state_out !== st && n < budget) begin
            tick(1);
            n++;
        end
        if (state_out !== st) begin
            vectors++;
            miscompares++;
            $display("FAIL wait_state: state %0d, expected %0d within %0d cycles", state_out, st, budget);
        end
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick(1);
            n++;
        end
        if (sb.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain_timeout: %0d transitions outstanding, expected 0 (next state %0d)",
                     sb.size(), sb[0].st);
            sb.delete();
        end
    endtask

    initial begin : monitor
        logic [2:0] prev;
        int dwell;
        exp_t e;
        prev  = 3'd0;
        dwell = 0;
        forever begin
            @(negedge clk_freerun);
            if (reset) begin
                prev  = state_out;
                dwell = 0;
            end else if (state_out !== prev) begin
                if (sb.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_transition: got state %0d from %0d, expected none", state_out, prev);
                end else begin
                    e = sb.pop_front();
                    chk("state_out", state_out, e.st);
                    chk("gt_reset_out", gt_reset_out, e.gt);
                    chk("rx_datapath_reset_out", rx_datapath_reset_out, e.rx);
                    chk("link_up", link_up, e.lu);
                    chk("fault", fault, e.flt);
                    chk("retry_count", retry_count, e.rc);
                    chk("loss_count", loss_count, e.lc);
                    if (e.dwell >= 0) chk("prev_state_cycles", dwell, e.dwell);
                end
                prev  = state_out;
                dwell = 1;
            end else begin
                dwell++;
            end
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_values(input string tag);
        chk({tag, "_state"}, state_out, 0);
        chk({tag, "_gt"}, gt_reset_out, 1);
        chk({tag, "_rx"}, rx_datapath_reset_out, 0);
        chk({tag, "_link_up"}, link_up, 0);
        chk({tag, "_fault"}, fault, 0);
        chk({tag, "_retry"}, retry_count, 0);
        chk({tag, "_loss"}, loss_count, 0);
    endtask

    initial begin
        tick(3);
        chk_reset_values("rst");

        // happy path: dones at cycle 10, link already high
        push(WAIT_DONE, 0, 0, RC);
        push(WAIT_LINK, 0, 0, 7);
        push(LINKED, 0, 0, SC);
        reset = 1'b0;
        tick(10);
        tx_done_in = 1'b1; rx_done_in = 1'b1; link_status_in = 1'b1;
        wait_drain(200);
        chk("happy_link_up", link_up, 1);
        chk("happy_retry", retry_count, 0);

        // single-cycle link loss
        push(RX_RESET, 1, 1, -1);
        push(WAIT_LINK, 1, 1, RC);
        push(LINKED, 0, 1, SC);
        link_status_in = 1'b0; tick(1); link_status_in = 1'b1;
        wait_drain(100);

        // stable-complete lands on the timeout cycle
        push(RX_RESET, 1, 2, -1);
        push(WAIT_LINK, 1, 2, RC);
        push(LINKED, 0, 2, TO);
        link_status_in = 1'b0;
        wait_state(WAIT_LINK, 50);
        tick(TO - SC);
        link_status_in = 1'b1;
        wait_drain(300);

        // rx_done and link drop together
        push(GT_RESET, 1, 2, -1);
        push(WAIT_DONE, 1, 2, RC);
        push(WAIT_LINK, 1, 2, 1);
        push(LINKED, 0, 2, SC);
        rx_done_in = 1'b0; link_status_in = 1'b0; tick(1);
        rx_done_in = 1'b1; link_status_in = 1'b1;
        wait_drain(100);

        // escalation to fault
        push(GT_RESET, 1, 2, -1);
        push(WAIT_DONE, 1, 2, RC);
        push(GT_RESET, 2, 2, TO);
        push(WAIT_DONE, 2, 2, RC);
        push(GT_RESET, 3, 2, TO);
        push(WAIT_DONE, 3, 2, RC);
        push(FAULT, 3, 2, TO);
        tx_done_in = 1'b0; rx_done_in = 1'b0;
        wait_drain(1000);
        tick(1000);
        chk("fault_held", fault, 1);
        chk("fault_state", state_out, FAULT);
        chk("fault_gt", gt_reset_out, 1);
        chk("fault_rx", rx_datapath_reset_out, 0);

        // button restart
        tx_done_in = 1'b1; rx_done_in = 1'b1; link_status_in = 1'b1;
`ifdef TDL_LINK_SUP_DEBOUNCE_EN
        btn_reset = 1'b1; tick(10); btn_reset = 1'b0;
        tick(40);
        chk("btn_short_state", state_out, FAULT);
        chk("btn_short_fault", fault, 1);
`else
        push(GT_RESET, 0, 2, -1);
        push(WAIT_DONE, 0, 2, RC);
        push(WAIT_LINK, 0, 2, 1);
        push(LINKED, 0, 2, SC);
        btn_reset = 1'b1; tick(10); btn_reset = 1'b0;
        wait_drain(100);
`endif
        push(GT_RESET, 0, 2, -1);
        push(WAIT_DONE, 0, 2, RC);
        push(WAIT_LINK, 0, 2, 1);
        push(LINKED, 0, 2, SC);
        btn_reset = 1'b1; tick(20); btn_reset = 1'b0;
        wait_drain(100);

        // reset in the middle of RX_RESET
        push(RX_RESET, 1, 3, -1);
        link_status_in = 1'b0;
        wait_state(RX_RESET, 20);
        link_status_in = 1'b1;
        tick(1);
        reset = 1'b1;
        tick(1);
        chk_reset_values("midrst");
        tick(1);
        push(WAIT_DONE, 0, 0, RC);
        push(WAIT_LINK, 0, 0, 1);
        push(LINKED, 0, 0, SC);
        reset = 1'b0;
        wait_drain(100);

        chk("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/tdl_link_supervisor.md
TDL_LINK_SUPERVISOR -- requirements
Module: tdl_link_supervisor

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- RESET_CYCLES, 1024: gt/rx reset pulse length in cycles.
- TIMEOUT_CYCLES, 10_000_000: wait-state timeout in cycles.
- STABLE_CYCLES, 65536: consecutive link_status_in highs required before declaring link up.
- MAX_RETRIES, 8: retries allowed before fault; range 1..255.
- DEBOUNCE_CYCLES, 1_000_000: button debounce length.

REQ-002 Ports SHALL be as follows, one per line: name  direction  width  meaning.
- clk_freerun  in  1  sole clock.
- reset  in  1  synchronous, active-high reset.
- btn_reset  in  1  asynchronous user restart request (GPIO button).
- tx_done_in  in  1  GT TX reset-done, already in the clk_freerun domain.
- rx_done_in  in  1  GT RX reset-done, already in the clk_freerun domain.
- link_status_in  in  1  link status from the TDL datapath.
- gt_reset_out  out  1  full transceiver reset.
- rx_datapath_reset_out  out  1  RX datapath reset.
- link_up  out  1  link qualified.
- fault  out  1  retries exhausted.
- retry_count  out  8  retries since last link-up.
- loss_count  out  16  link losses since reset; saturating.
- state_out  out  3  current state encoding.

REQ-003 The block SHALL use one clock, clk_freerun; reset SHALL be synchronous and active-high, named reset.

Function
REQ-004 States and encodings SHALL be GT_RESET=0, WAIT_DONE=1, WAIT_LINK=2, RX_RESET=3, LINKED=4, FAULT=5; state_out SHALL equal the current state.
REQ-005 One timer SHALL clear on every state entry; "expires" SHALL mean timer==N-1 for the relevant parameter N.
REQ-006 GT_RESET SHALL hold gt_reset_out=1 for exactly RESET_CYCLES cycles, then go to WAIT_DONE.
REQ-007 WAIT_DONE SHALL go to WAIT_LINK when tx_done_in and rx_done_in are both 1; on TIMEOUT_CYCLES expiry it SHALL retry to GT_RESET.
REQ-008 WAIT_LINK stable counter:
- increments while link_status_in=1; clears when link_status_in=0.
- on reaching STABLE_CYCLES, go to LINKED.
- on TIMEOUT_CYCLES expiry, retry to RX_RESET.
- if stable-complete and timeout occur in the same cycle, LINKED SHALL win.
REQ-009 RX_RESET SHALL hold rx_datapath_reset_out=1 for exactly RESET_CYCLES cycles, then go to WAIT_LINK.
REQ-010 LINKED:
- link_up=1 and retry_count cleared on entry.
- link_status_in=0 for one cycle: loss_count++ (saturating at 0xFFFF), retry to RX_RESET.
REQ-011 In WAIT_LINK or LINKED, tx_done_in=0 or rx_done_in=0 SHALL retry to GT_RESET; this SHALL take priority over REQ-008 and REQ-010.
REQ-012 Retry handling:
- if retry_count<MAX_RETRIES: retry_count++ and enter the target state.
- else: enter FAULT.
REQ-013 FAULT SHALL drive fault=1, gt_reset_out=1 and rx_datapath_reset_out=0, and SHALL persist until an accepted button request.
REQ-014 An accepted button request SHALL, from any state, clear retry_count and enter GT_RESET next cycle; it SHALL override all other transitions. loss_count SHALL be unaffected.
REQ-015 All outputs SHALL be registered and SHALL reflect the current state one cycle after entry, with no combinational input-to-output paths.

Reset
REQ-016 On reset=1 the block SHALL set: state=GT_RESET, timer=0, stable counter=0, gt_reset_out=1, rx_datapath_reset_out=0, link_up=0, fault=0, retry_count=0, loss_count=0, state_out=0.
REQ-017 Reset asserted mid-sequence SHALL abandon the sequence; GT_RESET SHALL then last a full RESET_CYCLES after reset deasserts.

Configuration
REQ-018 Macro TDL_LINK_SUP_DEBOUNCE_EN:
- defined: btn_reset is 2-FF synchronized, and a request is accepted once per press after DEBOUNCE_CYCLES consecutive high samples.
- undefined: btn_reset is 2-FF synchronized, and every rising edge of the synchronized signal is accepted.

Structure
REQ-019 Package tdl_link_sup_pkg SHALL hold the state enum typedef (3-bit) and the encodings of REQ-004.
REQ-020 Synchronizer and debounce logic SHALL be the sub-module tdl_link_sup_btn; its output SHALL be a one-cycle accept pulse.

Verification
REQ-021 Directed scenarios (bench parameters RESET_CYCLES=4, TIMEOUT_CYCLES=100, STABLE_CYCLES=8, MAX_RETRIES=3, DEBOUNCE_CYCLES=16):
- Happy path: release reset, dones high at cycle 10, link_status high -> gt_reset_out high exactly 4 cycles, link_up=1 eight cycles after WAIT_LINK entry, retry_count=0.
- Link loss: in LINKED, drop link_status_in for 1 cycle -> rx_datapath_reset_out high 4 cycles, loss_count=1, retry_count=1, relink restores link_up and clears retry_count.
- Escalation to fault: dones never assert -> three GT_RESET retries at 100-cycle intervals, then fault=1 and state_out=5; fault persists while held 1000 cycles.
- Button restart: with the macro defined, from FAULT, btn_reset high 10 cycles -> ignored; high 20 cycles -> one accept, GT_RESET, fault=0, retry_count=0, loss_count kept.
- Priority: stable-complete and timeout coincide -> LINKED; rx_done_in drops in the same cycle as link_status_in -> GT_RESET, not RX_RESET.
- Mid-sequence reset: reset asserted during RX_RESET -> all outputs at REQ-016 values next cycle.
